controller_fsm: RTL and testbench

Multi-cycle instruction sequencer for the CR16 core; sits directly upstream of `datapath` and drives all of its control inputs. Each cycle it does one of three things: fetches a 16-bit instruction from a synchronous memory, decodes it, or issues register-select, opcode, immediate and write-enable controls. It also issues load/store memory accesses, latches ALU status flags, and resolves conditional branches.

---
 rtl/controller_fsm.sv | 226 ++++++++++++++++++++++
 tb/tb_controller_fsm.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC(/MEM) sequencer for the CR16 core.
// Drives every datapath control input; outputs are combinational from state, IR and inputs.
module controller_fsm #(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_ENABLE,
  input  logic [15:0] I_MEM_RDATA,
  input  logic [15:0] I_A,
  input  logic [15:0] I_B,
  input  logic [4:0]  I_STATUS_FLAGS,
  output logic [15:0] O_MEM_ADDR,
  output logic [15:0] O_MEM_WDATA,
  output logic        O_MEM_WE,
  output logic [15:0] O_REG_WRITE_ENABLE,
  output logic [3:0]  O_REG_A_SELECT,
  output logic [3:0]  O_REG_B_SELECT,
  output logic [3:0]  O_OPCODE,
  output logic [15:0] O_IMMEDIATE,
  output logic        O_IMMEDIATE_SELECT,
  output logic [15:0] O_REGFILE_DATA,
  output logic        O_REGFILE_DATA_SELECT,
  output logic [15:0] O_PC,
  output logic        O_HALTED
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_SUBI  = 4'b0010;
  localparam logic [3:0] OP_MOVI  = 4'b0011;
  localparam logic [3:0] OP_MEMGR = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_HALT = 4'b0001;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_MOV  = 4'b1101;

  // Datapath ALU encoding: ADD ADDU ADDC SUB SUBC CMP AND OR XOR LSH RSH ARSH = 0..11.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd7;
  localparam logic [3:0] ALU_MAX = 4'd11;

  localparam int FLAG_C = 4;
  localparam int FLAG_Z = 1;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [4:0]  flags_q, flags_d;

  logic [3:0]  op, rd, ext, rs;
  logic [15:0] imm_sext, rd_onehot;
  logic [15:0] reg_we;
  logic        mem_we;
  logic        latch_flags;

  assign op        = ir_q[15:12];
  assign rd        = ir_q[11:8];
  assign ext       = ir_q[7:4];
  assign rs        = ir_q[3:0];
  assign imm_sext  = {{8{ir_q[7]}}, ir_q[7:0]};
  assign rd_onehot = 16'h0001 << rd;

  assign O_PC     = pc_q;
  assign O_HALTED = (state_q == S_HALT);

  // L, F and N are latched for completeness but no branch condition reads them.
  logic unused_flags;
  assign unused_flags = ^{flags_q[3:2], flags_q[0]};

  function automatic logic branch_taken(input logic [3:0] cond, input logic [4:0] f);
    case (cond)
      4'd0:    return f[FLAG_Z];
      4'd1:    return !f[FLAG_Z];
      4'd2:    return f[FLAG_C];
      4'd3:    return !f[FLAG_C];
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d               = state_q;
    pc_d                  = pc_q;
    ir_d                  = ir_q;
    flags_d               = flags_q;
    latch_flags           = 1'b0;
    reg_we                = '0;
    mem_we                = 1'b0;
    O_MEM_ADDR            = pc_q;
    O_MEM_WDATA           = '0;
    O_REG_A_SELECT        = '0;
    O_REG_B_SELECT        = '0;
    O_OPCODE              = ALU_ADD;
    O_IMMEDIATE           = '0;
    O_IMMEDIATE_SELECT    = 1'b0;
    O_REGFILE_DATA        = '0;
    O_REGFILE_DATA_SELECT = 1'b0;

    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = I_MEM_RDATA;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 16'd1;
        case (op)
          OP_RTYPE: begin
            if (ext <= ALU_MAX) begin
              O_REG_A_SELECT = rd;
              O_REG_B_SELECT = rs;
              O_OPCODE       = ext;
              reg_we         = rd_onehot;
              latch_flags    = 1'b1;
            end else if (ext == EXT_MOV) begin
              O_REG_A_SELECT = rs;
              O_REG_B_SELECT = rs;
              O_OPCODE       = ALU_OR;
              reg_we         = rd_onehot;
            end
          end
          OP_ADDI, OP_SUBI: begin
            O_REG_A_SELECT     = rd;
            O_IMMEDIATE        = imm_sext;
            O_IMMEDIATE_SELECT = 1'b1;
            O_OPCODE           = (op == OP_ADDI) ? ALU_ADD : ALU_SUB;
            reg_we             = rd_onehot;
            latch_flags        = 1'b1;
          end
          OP_MOVI: begin
            O_REGFILE_DATA        = {8'h00, ir_q[7:0]};
            O_REGFILE_DATA_SELECT = 1'b1;
            reg_we                = rd_onehot;
          end
          OP_LUI: begin
            O_REGFILE_DATA        = {ir_q[7:0], 8'h00};
            O_REGFILE_DATA_SELECT = 1'b1;
            reg_we                = rd_onehot;
          end
          OP_MEMGR: begin
            case (ext)
              EXT_LOAD: begin
                O_REG_A_SELECT = rs;
                O_MEM_ADDR     = I_A;
                pc_d           = pc_q;
                state_d        = S_MEM;
              end
              EXT_STOR: begin
                O_REG_A_SELECT = rs;
                O_REG_B_SELECT = rd;
                O_MEM_ADDR     = I_A;
                O_MEM_WDATA    = I_B;
                mem_we         = 1'b1;
              end
              EXT_HALT: begin
                pc_d    = pc_q;
                state_d = S_HALT;
              end
              default: ;
            endcase
          end
          OP_BCOND: begin
            if (branch_taken(rd, flags_q)) pc_d = pc_q + imm_sext;
          end
          default: ;
        endcase
        if (latch_flags) flags_d = I_STATUS_FLAGS;
      end
      S_MEM: begin
        // Keep the load address up so a stalled MEM cycle still sees the same read data.
        O_REG_A_SELECT        = rs;
        O_MEM_ADDR            = I_A;
        O_REGFILE_DATA        = I_MEM_RDATA;
        O_REGFILE_DATA_SELECT = 1'b1;
        reg_we                = rd_onehot;
        pc_d                  = pc_q + 16'd1;
        state_d               = S_FETCH;
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase

    if (!I_ENABLE) begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      flags_d = flags_q;
      reg_we  = '0;
      mem_we  = 1'b0;
    end

    O_REG_WRITE_ENABLE = reg_we;
    O_MEM_WE           = mem_we;
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!I_NRESET) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_controller_fsm.sv
// Directed, table-driven bench for controller_fsm with a small synchronous program memory.
// Each table row is one clock cycle: inputs to drive and every output expected in that cycle.
module tb_controller_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] mem_rdata = '0;
  logic [15:0] i_a, i_b;
  logic [4:0]  i_flags;
  logic [15:0] mem_addr, mem_wdata, reg_we, imm, rf_data, pc;
  logic        mem_we, imm_sel, rf_sel, halted;
  logic [3:0]  a_sel, b_sel, opcode;

  always #5 clk = ~clk;

  controller_fsm #(.PC_RESET(16'h0000)) dut (
    .I_CLK                (clk),
    .I_NRESET             (rst_n),
    .I_ENABLE             (en),
    .I_MEM_RDATA          (mem_rdata),
    .I_A                  (i_a),
    .I_B                  (i_b),
    .I_STATUS_FLAGS       (i_flags),
    .O_MEM_ADDR           (mem_addr),
    .O_MEM_WDATA          (mem_wdata),
    .O_MEM_WE             (mem_we),
    .O_REG_WRITE_ENABLE   (reg_we),
    .O_REG_A_SELECT       (a_sel),
    .O_REG_B_SELECT       (b_sel),
    .O_OPCODE             (opcode),
    .O_IMMEDIATE          (imm),
    .O_IMMEDIATE_SELECT   (imm_sel),
    .O_REGFILE_DATA       (rf_data),
    .O_REGFILE_DATA_SELECT(rf_sel),
    .O_PC                 (pc),
    .O_HALTED             (halted)
  );

  // Synchronous program/data memory: read data valid one cycle after the address.
  logic [15:0] mem [0:255];
  always @(posedge clk) mem_rdata <= mem[mem_addr[7:0]];

  typedef struct {
    logic        en;
    logic [4:0]  flags;
    logic [15:0] a, b;
    logic [15:0] pc, addr, we;
    logic [3:0]  asel, bsel, opc;
    logic [15:0] imm;
    logic        imms;
    logic [15:0] rfd;
    logic        rfs, mwe;
    logic [15:0] wd;
    logic        halt;
    logic        relax;  // skip address/A-select in MEM, where they carry no defined value
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic vec_t idle(input logic [15:0] p);
    vec_t v;
    v.en = 1'b1; v.flags = '0; v.a = '0; v.b = '0;
    v.pc = p; v.addr = p; v.we = '0;
    v.asel = '0; v.bsel = '0; v.opc = '0;
    v.imm = '0; v.imms = 1'b0; v.rfd = '0; v.rfs = 1'b0;
    v.mwe = 1'b0; v.wd = '0; v.halt = 1'b0; v.relax = 1'b0;
    return v;
  endfunction

  task automatic fetch_decode(input logic [15:0] p);
    tbl.push_back(idle(p));
    tbl.push_back(idle(p));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc"},    pc,       16'h0000);
    check({tag, ".addr"},  mem_addr, 16'h0000);
    check({tag, ".we"},    reg_we,   16'h0000);
    check({tag, ".asel"},  a_sel,    4'h0);
    check({tag, ".bsel"},  b_sel,    4'h0);
    check({tag, ".opc"},   opcode,   4'h0);
    check({tag, ".imm"},   imm,      16'h0000);
    check({tag, ".imms"},  imm_sel,  1'b0);
    check({tag, ".rfd"},   rf_data,  16'h0000);
    check({tag, ".rfs"},   rf_sel,   1'b0);
    check({tag, ".mwe"},   mem_we,   1'b0);
    check({tag, ".wd"},    mem_wdata, 16'h0000);
    check({tag, ".halt"},  halted,   1'b0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]     = 16'h3105;  // MOVI R1,5
    mem[1]     = 16'h3203;  // MOVI R2,3
    mem[2]     = 16'h0102;  // ADD  R1,R2
    mem[3]     = 16'h2101;  // SUBI R1,1
    mem[4]     = 16'hC0FE;  // BEQ  -2
    mem[5]     = 16'h4304;  // LOAD R3,[R4]
    mem[6]     = 16'h4544;  // STOR R5,[R4]
    mem[7]     = 16'hF7AB;  // LUI  R7,0xAB
    mem[8]     = 16'h06D1;  // MOV  R6,R1
    mem[9]     = 16'h4010;  // HALT
    mem[8'h40] = 16'hBEEF;

    // MOVI R1,5
    fetch_decode(16'd0);
    v = idle(16'd0); v.we = 16'h0002; v.rfd = 16'h0005; v.rfs = 1'b1; tbl.push_back(v);
    // MOVI R2,3 with one stalled EXEC cycle: controls shown, write suppressed
    fetch_decode(16'd1);
    v = idle(16'd1); v.rfd = 16'h0003; v.rfs = 1'b1; v.en = 1'b0; tbl.push_back(v);
    v.en = 1'b1; v.we = 16'h0004; tbl.push_back(v);
    // Two passes of ADD / SUBI / BEQ: first with Z set (taken), then with Z clear
    for (int p = 0; p < 2; p++) begin
      fetch_decode(16'd2);
      v = idle(16'd2); v.asel = 4'd1; v.bsel = 4'd2; v.opc = 4'd0; v.we = 16'h0002; tbl.push_back(v);
      fetch_decode(16'd3);
      v = idle(16'd3); v.flags = (p == 0) ? 5'b00010 : 5'b00000;
      v.asel = 4'd1; v.imm = 16'h0001; v.imms = 1'b1; v.opc = 4'd3; v.we = 16'h0002;
      tbl.push_back(v);
      fetch_decode(16'd4);
      tbl.push_back(idle(16'd4));
    end
    // LOAD R3,[R4] with enable low for 3 EXEC cycles
    fetch_decode(16'd5);
    v = idle(16'd5); v.a = 16'h0040; v.asel = 4'd4; v.addr = 16'h0040; v.en = 1'b0;
    for (int k = 0; k < 3; k++) tbl.push_back(v);
    v.en = 1'b1; tbl.push_back(v);
    v = idle(16'd5); v.a = 16'h0040; v.relax = 1'b1;
    v.rfd = 16'hBEEF; v.rfs = 1'b1; v.we = 16'h0008; tbl.push_back(v);
    // STOR R5,[R4]
    fetch_decode(16'd6);
    v = idle(16'd6); v.a = 16'h0080; v.b = 16'h1234; v.asel = 4'd4; v.bsel = 4'd5;
    v.addr = 16'h0080; v.mwe = 1'b1; v.wd = 16'h1234; tbl.push_back(v);
    // LUI R7,0xAB
    fetch_decode(16'd7);
    v = idle(16'd7); v.rfd = 16'hAB00; v.rfs = 1'b1; v.we = 16'h0080; tbl.push_back(v);
    // MOV R6,R1
    fetch_decode(16'd8);
    v = idle(16'd8); v.asel = 4'd1; v.bsel = 4'd1; v.opc = 4'd7; v.we = 16'h0040; tbl.push_back(v);
    // HALT, then 20 frozen cycles
    fetch_decode(16'd9);
    tbl.push_back(idle(16'd9));
    for (int k = 0; k < 20; k++) begin
      v = idle(16'd9); v.halt = 1'b1; tbl.push_back(v);
    end

    rst_n = 1'b0; en = 1'b1; i_a = '0; i_b = '0; i_flags = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      v = tbl[i];
      en = v.en; i_flags = v.flags; i_a = v.a; i_b = v.b;
      #1;
      check($sformatf("r%0d.pc", i),   pc,      v.pc);
      if (!v.relax) begin
        check($sformatf("r%0d.addr", i), mem_addr, v.addr);
        check($sformatf("r%0d.asel", i), a_sel,    v.asel);
      end
      check($sformatf("r%0d.we", i),   reg_we,    v.we);
      check($sformatf("r%0d.bsel", i), b_sel,     v.bsel);
      check($sformatf("r%0d.opc", i),  opcode,    v.opc);
      check($sformatf("r%0d.imm", i),  imm,       v.imm);
      check($sformatf("r%0d.imms", i), imm_sel,   v.imms);
      check($sformatf("r%0d.rfd", i),  rf_data,   v.rfd);
      check($sformatf("r%0d.rfs", i),  rf_sel,    v.rfs);
      check($sformatf("r%0d.mwe", i),  mem_we,    v.mwe);
      check($sformatf("r%0d.wd", i),   mem_wdata, v.wd);
      check($sformatf("r%0d.halt", i), halted,    v.halt);
      step();
    end

    // Reset leaves HALT; then a LOAD at address 0 is interrupted by reset during MEM.
    mem[0] = 16'h4304;
    en = 1'b1; i_a = 16'h0040; i_b = '0; i_flags = '0;
    rst_n = 1'b0;
    #1;
    check_reset("halt_rst");
    step();
    rst_n = 1'b1;
    step();                                   // DECODE
    step();                                   // EXEC
    check("ld_exec.addr", mem_addr, 16'h0040);
    check("ld_exec.asel", a_sel, 4'd4);
    step();                                   // MEM
    check("ld_mem.we",  reg_we,  16'h0008);
    check("ld_mem.rfd", rf_data, 16'hBEEF);
    rst_n = 1'b0;
    #1;
    check_reset("mem_rst");
    step();
    check("mem_rst_edge.we", reg_we, 16'h0000);
    check("mem_rst_edge.pc", pc,     16'h0000);
    rst_n = 1'b1;
    #1;
    check("restart.addr", mem_addr, 16'h0000);
    check("restart.rfs",  rf_sel,   1'b0);
    step();                                   // DECODE
    step();                                   // EXEC again
    check("restart_exec.addr", mem_addr, 16'h0040);
    check("restart_exec.pc",   pc,       16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
